// File: rtl/neuron_accumulator.sv
// neuron_accumulator: streams (value, weight) pairs for one neuron, accumulates
// the full-precision products, adds a bias on the final beat and emits one
// saturated Q-format pre-activation sum per frame of NUM_INPUTS beats.
module neuron_accumulator #(
    parameter int FIXED_BITS      = 8,
    parameter int FRACTIONAL_BITS = 8,
    parameter int NUM_INPUTS      = 4,
    localparam int W              = FIXED_BITS + FRACTIONAL_BITS,
    localparam int F              = FRACTIONAL_BITS,
    localparam int CNT_W          = $clog2(NUM_INPUTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_value,
    input  logic [W-1:0]     in_weight,
    input  logic [W-1:0]     bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_sat,
    output logic [CNT_W-1:0] beat_count
);

    // Wide enough to hold NUM_INPUTS full products plus the shifted bias
    // without ever wrapping, so only the final clip can lose information.
    localparam int ACC_W = 2 * W + CNT_W + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

    localparam logic signed [ACC_W-1:0] SUM_MAX = {{(ACC_W - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN = {{(ACC_W - W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic [W-1:0]             sum_reg, sum_next;
    logic                     sat_reg, sat_next;

    logic signed [2*W-1:0]    product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  total;
    logic signed [ACC_W-1:0]  shifted;
    logic [W-1:0]             clipped_sum;
    logic                     clipped;

    // Full-precision Q(2F) product and the bias aligned to the same scale.
    assign product     = $signed(in_value) * $signed(in_weight);
    assign product_ext = {{(ACC_W - 2 * W){product[2*W-1]}}, product};
    assign bias_ext    = {{(ACC_W - W - F){bias[W-1]}}, bias, {F{1'b0}}};

    // Final-beat result: rescale to Q(F) by flooring, then clip to W bits.
    always_comb begin
        total       = acc_reg + product_ext + bias_ext;
        shifted     = total >>> F;
        clipped_sum = shifted[W-1:0];
        clipped     = 1'b0;
        if (shifted > SUM_MAX) begin
            clipped_sum = {1'b0, {(W - 1){1'b1}}};
            clipped     = 1'b1;
        end else if (shifted < SUM_MIN) begin
            clipped_sum = {1'b1, {(W - 1){1'b0}}};
            clipped     = 1'b1;
        end
    end

    // Next-state and datapath updates; handshakes only move state when accepted.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        sat_next   = sat_reg;
        case (state_reg)
            ACCUM: begin
                if (in_valid) begin
                    if (count_reg == LAST_BEAT) begin
                        acc_next   = '0;
                        count_next = '0;
                        sum_next   = clipped_sum;
                        sat_next   = clipped;
                        state_next = OUTPUT;
                    end else begin
                        acc_next   = acc_reg + product_ext;
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // State register; reset wins over any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            count_reg <= '0;
            sum_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
            sat_reg   <= sat_next;
        end
    end

    assign in_ready   = (state_reg == ACCUM);
    assign out_valid  = (state_reg == OUTPUT);
    assign out_sum    = sum_reg;
    assign out_sat    = sat_reg;
    assign beat_count = count_reg;

endmodule
